conv_mesh_seq: RTL

Parametrised ROWS×COLS signed MAC mesh with its own sequencer. It accumulates the outer product of a kernel vector and a neuron vector over a programmable number of beats, then drains the accumulators one row per beat through a valid/ready port. This is the next-generation convolutional unit. It replaces externally driven per-PE control with an internal FSM, handshaking and multi-pass accumulation.

---
 rtl/conv_mesh_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/conv_mesh_seq.sv
// ---------------------------------------------------------------------------
// conv_mesh_seq
//
// ROWS x COLS signed multiply-accumulate mesh with its own sequencer. One pass:
//   1. IDLE    : wait for start; latch k_len; optionally clear the accumulators.
//   2. COMPUTE : each accepted operand beat adds the outer product k (x) n
//                into the accumulator array.
//   3. DRAIN   : present one accumulator row per beat on a valid/ready port,
//                row 0 first. After the last row, pulse done and return to IDLE.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous, active-high reset
//   start      begin a pass (sampled in IDLE only)
//   k_len      accumulation beats for the pass (sampled with start)
//   acc_mode   sampled with start: 0 = clear accumulators, 1 = keep them
//   in_valid   operand beat valid
//   in_ready   mesh accepts an operand beat (high throughout COMPUTE)
//   kBuffIn    kernel vector, lane i at [W*(i+1)-1 -: W]
//   nBuffIn    neuron vector, lane j at [W*(j+1)-1 -: W]
//   out_valid  drain row valid
//   out_ready  consumer accepts the drain row
//   out_data   accumulators of the current drain row, column j at
//              [ACC_W*(j+1)-1 -: ACC_W]; zero outside DRAIN
//   out_last   current drain row is ROWS-1
//   busy       sequencer not in IDLE
//   done       one-cycle pulse after the last drain transfer
//
// Parameters: ROWS, COLS, W (operand width), ACC_W (accumulator width,
// must be >= 2*W), K_W (width of k_len).
//
// Build option
//   CONV_MESH_SATURATE_EN : when defined, every accumulate clamps to the
//   signed ACC_W range instead of wrapping modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module conv_mesh_seq #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int W     = 16,
    parameter int ACC_W = 40,
    parameter int K_W   = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    input  logic                    acc_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*W-1:0]       kBuffIn,
    input  logic [COLS*W-1:0]       nBuffIn,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*ACC_W-1:0]   out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t           state;
    logic [K_W-1:0]   beat_cnt;
    logic [ROW_W-1:0] row;

    // Read-only view of every PE accumulator, used by the drain mux.
    logic [ACC_W-1:0] acc_view [ROWS][COLS];

    // Mesh-wide control strobes shared by all PEs.
    logic clear_acc;
    logic mac_en;

    assign clear_acc = (state == IDLE) && start && !acc_mode;
    assign mac_en    = (state == COMPUTE) && in_valid;

    // -----------------------------------------------------------------------
    // Sequencer. All handshake/status outputs are registered and updated in
    // lock-step with the state so they never glitch.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            row       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        beat_cnt <= k_len;
                        row      <= '0;
                        busy     <= 1'b1;
                        if (k_len != '0) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b1;
                        end else begin
                            // Nothing to accumulate: drain whatever the
                            // accumulators hold (zeros if just cleared).
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                            out_last  <= (row == LAST_ROW) || (ROWS == 1);
                        end
                    end
                end

                COMPUTE: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt - K_W'(1);
                        if (beat_cnt == K_W'(1)) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_last  <= (ROWS == 1);
                        end
                    end
                end

                DRAIN: begin
                    if (out_ready) begin
                        if (row == LAST_ROW) begin
                            state     <= IDLE;
                            row       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            row      <= row + ROW_W'(1);
                            out_last <= ((row + ROW_W'(1)) == LAST_ROW);
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // MAC mesh: PE (gi, gj) accumulates k[gi] * n[gj].
    // -----------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                logic signed [W-1:0]     k_lane;
                logic signed [W-1:0]     n_lane;
                logic signed [2*W-1:0]   prod;
                logic signed [ACC_W-1:0] prod_ext;
                logic signed [ACC_W-1:0] acc_reg;
                logic signed [ACC_W-1:0] acc_next;

                assign k_lane = kBuffIn[W*(gi+1)-1 -: W];
                assign n_lane = nBuffIn[W*(gj+1)-1 -: W];
                assign prod   = k_lane * n_lane;
                // Signed size cast sign-extends the full-precision product.
                assign prod_ext = ACC_W'(prod);

`ifdef CONV_MESH_SATURATE_EN
                // One guard bit exposes overflow: the top two bits of the
                // widened sum disagree exactly when the ACC_W result would
                // have wrapped. The guard bit gives the true sign.
                logic [ACC_W:0] sum_wide;
                assign sum_wide = {acc_reg[ACC_W-1], acc_reg}
                                + {prod_ext[ACC_W-1], prod_ext};
                always_comb begin
                    acc_next = sum_wide[ACC_W-1:0];
                    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
                        if (sum_wide[ACC_W])
                            acc_next = {1'b1, {(ACC_W-1){1'b0}}};
                        else
                            acc_next = {1'b0, {(ACC_W-1){1'b1}}};
                    end
                end
`else
                assign acc_next = acc_reg + prod_ext;
`endif

                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        acc_reg <= '0;
                    end else if (clear_acc) begin
                        acc_reg <= '0;
                    end else if (mac_en) begin
                        acc_reg <= acc_next;
                    end
                end

                assign acc_view[gi][gj] = acc_reg;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Drain mux. Accumulators are frozen during DRAIN, so the selected row is
    // stable under back-pressure.
    // -----------------------------------------------------------------------
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int j = 0; j < COLS; j++) begin
                out_data[ACC_W*j +: ACC_W] = acc_view[row][j];
            end
        end
    end

endmodule
